// File: rtl/shot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : shot_scheduler
//  Purpose  : Sequences firing for the local tank (mouse) and the opponent
//             tank (link request). Each channel turns a request into a single
//             cycle fire pulse, waits for its gun controller to fly the bullet,
//             then enforces a reload cooldown. Tracks hit points, declares the
//             winner, and queues shot/hit events for the serial-link TX port.
//  Ports    : clk, rst (async, active-low)
//             new_game             - synchronous match restart (top priority)
//             left_click, select   - raw mouse button level / local tank select
//             shot_req_op          - opponent fire request pulse
//             busy, busy_op        - gun controllers not idle
//             hit_local, hit_op    - bullet hit pulses
//             fire, fire_op        - fire pulses to the gun controllers
//             reloading(_op)       - channel is in its cooldown
//             hp, hp_op            - hit points
//             game_over, winner    - match result (01 local, 10 opp, 11 draw)
//             tx_valid/tx_event/tx_ready - event stream to the link
//  Revision : 1.0 - initial release
// ============================================================================
module shot_scheduler #(
    parameter int RELOAD_CYCLES = 195000000,
    parameter int HP_INIT       = 3,
    parameter int START_TO      = 8,
    parameter int CNT_W         = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       new_game,
    input  logic       left_click,
    input  logic       select,
    input  logic       shot_req_op,
    input  logic       busy,
    input  logic       busy_op,
    input  logic       hit_local,
    input  logic       hit_op,
    output logic       fire,
    output logic       fire_op,
    output logic       reloading,
    output logic       reloading_op,
    output logic [1:0] hp,
    output logic [1:0] hp_op,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       tx_valid,
    output logic [1:0] tx_event,
    input  logic       tx_ready
);

    localparam int TO_W = (START_TO > 1) ? $clog2(START_TO) : 1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ARM    = 2'd1;
    localparam logic [1:0] c_FLIGHT = 2'd2;
    localparam logic [1:0] c_RELOAD = 2'd3;

    localparam logic [1:0] c_EV_FIRED = 2'b01;
    localparam logic [1:0] c_EV_HIT   = 2'b10;
    localparam logic [1:0] c_HP_INIT  = 2'(HP_INIT);

    // ------------------------------------------------------------------
    // Shared state
    // ------------------------------------------------------------------
    logic       click_q, click_d;
    logic [1:0] hp_q, hp_d;
    logic [1:0] hp_op_q, hp_op_d;
    logic       game_over_q, game_over_d;
    logic [1:0] winner_q, winner_d;
    logic [1:0] q0_q, q0_d;
    logic [1:0] q1_q, q1_d;
    logic [1:0] qcnt_q, qcnt_d;

    // Index 0 = local channel, index 1 = opponent channel
    logic [1:0] w_req;
    logic [1:0] w_busy;
    logic [1:0] w_fire;
    logic [1:0] w_reload;

    assign click_d  = left_click;
    // Edge-detect the raw button so a held click fires only once
    assign w_req[0] = select & left_click & ~click_q;
    assign w_req[1] = shot_req_op;
    assign w_busy   = {busy_op, busy};

    // ------------------------------------------------------------------
    // Per-channel firing FSM
    // ------------------------------------------------------------------
    generate
        for (genvar ch = 0; ch < 2; ch++) begin : g_ch
            logic [1:0]       state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [TO_W-1:0]  to_q, to_d;
            logic             fire_q, fire_d;

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                to_d    = to_q;
                fire_d  = 1'b0;
                if (new_game) begin
                    state_d = c_IDLE;
                    cnt_d   = '0;
                    to_d    = '0;
                end else begin
                    case (state_q)
                        c_IDLE: begin
                            if (w_req[ch] && !game_over_q) begin
                                state_d = c_ARM;
                                to_d    = '0;
                                fire_d  = 1'b1;
                            end
                        end
                        c_ARM: begin
                            // The fire-pulse cycle is the first ARM cycle, so the
                            // START_TO-th cycle without busy gives up the shot.
                            if (w_busy[ch]) begin
                                state_d = c_FLIGHT;
                            end else if (to_q == TO_W'(START_TO - 1)) begin
                                state_d = c_RELOAD;
                                cnt_d   = '0;
                            end else begin
                                to_d = to_q + 1'b1;
                            end
                        end
                        c_FLIGHT: begin
                            if (!w_busy[ch]) begin
                                state_d = c_RELOAD;
                                cnt_d   = '0;
                            end
                        end
                        c_RELOAD: begin
                            if (cnt_q == CNT_W'(RELOAD_CYCLES - 1)) begin
                                state_d = c_IDLE;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        default: state_d = c_IDLE;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= c_IDLE;
                    cnt_q   <= '0;
                    to_q    <= '0;
                    fire_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    to_q    <= to_d;
                    fire_q  <= fire_d;
                end
            end

            assign w_fire[ch]   = fire_q;
            assign w_reload[ch] = (state_q == c_RELOAD);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Hit points and match result
    // ------------------------------------------------------------------
    always_comb begin
        hp_d        = hp_q;
        hp_op_d     = hp_op_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        if (new_game) begin
            hp_d        = c_HP_INIT;
            hp_op_d     = c_HP_INIT;
            game_over_d = 1'b0;
            winner_d    = 2'b00;
        end else begin
            if (!game_over_q) begin
                if (hit_op && hp_q != 2'd0) begin
                    hp_d = hp_q - 2'd1;
                end
                if (hit_local && hp_op_q != 2'd0) begin
                    hp_op_d = hp_op_q - 2'd1;
                end
                // Result is latched once, from the hp values of the cycle in
                // which the first zero became visible.
                if (hp_q == 2'd0 || hp_op_q == 2'd0) begin
                    game_over_d = 1'b1;
                    winner_d    = {hp_q == 2'd0, hp_op_q == 2'd0};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Two-entry event queue; head is always q0. Pop is applied before the
    // pushes so a full queue can still accept while draining.
    // ------------------------------------------------------------------
    logic w_push_fire;
    logic w_push_hit;
    logic w_pop;

    assign w_push_fire = w_fire[0];
    assign w_push_hit  = hit_local & ~game_over_q;
    assign w_pop       = tx_valid & tx_ready;

    always_comb begin
        q0_d   = q0_q;
        q1_d   = q1_q;
        qcnt_d = qcnt_q;
        if (new_game) begin
            q0_d   = 2'b00;
            q1_d   = 2'b00;
            qcnt_d = 2'd0;
        end else begin
            if (w_pop) begin
                q0_d   = q1_q;
                qcnt_d = qcnt_q - 2'd1;
            end
            // "local fired" has priority over "hit confirmed"
            if (w_push_fire && qcnt_d != 2'd2) begin
                if (qcnt_d == 2'd0) begin
                    q0_d = c_EV_FIRED;
                end else begin
                    q1_d = c_EV_FIRED;
                end
                qcnt_d = qcnt_d + 2'd1;
            end
            if (w_push_hit && qcnt_d != 2'd2) begin
                if (qcnt_d == 2'd0) begin
                    q0_d = c_EV_HIT;
                end else begin
                    q1_d = c_EV_HIT;
                end
                qcnt_d = qcnt_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            click_q     <= 1'b0;
            hp_q        <= c_HP_INIT;
            hp_op_q     <= c_HP_INIT;
            game_over_q <= 1'b0;
            winner_q    <= 2'b00;
            q0_q        <= 2'b00;
            q1_q        <= 2'b00;
            qcnt_q      <= 2'd0;
        end else begin
            click_q     <= click_d;
            hp_q        <= hp_d;
            hp_op_q     <= hp_op_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
            qcnt_q      <= qcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fire         = w_fire[0];
    assign fire_op      = w_fire[1];
    assign reloading    = w_reload[0];
    assign reloading_op = w_reload[1];
    assign hp           = hp_q;
    assign hp_op        = hp_op_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;
    assign tx_valid     = (qcnt_q != 2'd0);
    assign tx_event     = tx_valid ? q0_q : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_shot_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shot_scheduler
//  Purpose  : Directed self-checking bench for shot_scheduler with a short
//             reload (20 cycles) and START_TO = 8. Inputs change 1 time unit
//             after each rising edge; outputs are sampled at the same point.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shot_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       new_game = 1'b0;
    logic       left_click = 1'b0;
    logic       select = 1'b0;
    logic       shot_req_op = 1'b0;
    logic       busy = 1'b0;
    logic       busy_op = 1'b0;
    logic       hit_local = 1'b0;
    logic       hit_op = 1'b0;
    logic       tx_ready = 1'b1;
    logic       fire, fire_op, reloading, reloading_op;
    logic [1:0] hp, hp_op, winner, tx_event;
    logic       game_over, tx_valid;

    int vectors = 0;
    int errors  = 0;

    shot_scheduler #(
        .RELOAD_CYCLES (20),
        .HP_INIT       (3),
        .START_TO      (8),
        .CNT_W         (28)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .new_game     (new_game),
        .left_click   (left_click),
        .select       (select),
        .shot_req_op  (shot_req_op),
        .busy         (busy),
        .busy_op      (busy_op),
        .hit_local    (hit_local),
        .hit_op       (hit_op),
        .fire         (fire),
        .fire_op      (fire_op),
        .reloading    (reloading),
        .reloading_op (reloading_op),
        .hp           (hp),
        .hp_op        (hp_op),
        .game_over    (game_over),
        .winner       (winner),
        .tx_valid     (tx_valid),
        .tx_event     (tx_event),
        .tx_ready     (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int f;

        // ---------------- reset ----------------
        tick();
        tick();
        chk("rst_fire", fire, 1'b0);
        chk("rst_reloading", reloading, 1'b0);
        chk("rst_hp", hp, 2'd3);
        chk("rst_hp_op", hp_op, 2'd3);
        chk("rst_game_over", game_over, 1'b0);
        chk("rst_winner", winner, 2'b00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_event", tx_event, 2'b00);
        rst = 1'b1;
        tick();

        // ---------------- click, flight, reload ----------------
        select = 1'b1;
        left_click = 1'b1;
        tick();
        chk("click_fire", fire, 1'b1);
        left_click = 1'b0;
        tick();
        chk("click_fire_one_cycle", fire, 1'b0);
        busy = 1'b1;
        repeat (10) tick();
        chk("flight_no_reload", reloading, 1'b0);
        busy = 1'b0;
        tick();
        chk("reload_start", reloading, 1'b1);
        n = 1;
        f = 0;
        for (int i = 0; i < 40 && reloading; i++) begin
            left_click = (i == 3);
            tick();
            if (reloading) n++;
            f += int'(fire);
        end
        left_click = 1'b0;
        chk("reload_len", n, 20);
        chk("click_in_reload_dropped", f, 0);
        left_click = 1'b1;
        tick();
        chk("click_after_reload", fire, 1'b1);

        // ---------------- lost shot timeout ----------------
        f = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            f += int'(fire);
            if (k == 7) chk("timeout_not_yet", reloading, 1'b0);
            if (k == 8) chk("timeout_reload", reloading, 1'b1);
        end
        chk("timeout_no_refire", f, 0);
        left_click = 1'b0;
        repeat (30) tick();
        chk("timeout_back_idle", reloading, 1'b0);

        // ---------------- held click fires once ----------------
        left_click = 1'b1;
        f = 0;
        repeat (50) begin
            tick();
            f += int'(fire);
        end
        chk("held_click_once", f, 1);
        left_click = 1'b0;
        tick();

        // ---------------- three hits on local tank ----------------
        hit_op = 1'b1;
        tick();
        chk("hp_2", hp, 2'd2);
        tick();
        chk("hp_1", hp, 2'd1);
        tick();
        chk("hp_0", hp, 2'd0);
        chk("go_delayed", game_over, 1'b0);
        hit_op = 1'b0;
        tick();
        chk("go_set", game_over, 1'b1);
        chk("winner_opp", winner, 2'b10);
        chk("hp_op_untouched", hp_op, 2'd3);
        left_click = 1'b1;
        shot_req_op = 1'b1;
        tick();
        chk("go_blocks_fire", fire, 1'b0);
        chk("go_blocks_fire_op", fire_op, 1'b0);
        left_click = 1'b0;
        shot_req_op = 1'b0;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        chk("ng_hp", hp, 2'd3);
        chk("ng_hp_op", hp_op, 2'd3);
        chk("ng_game_over", game_over, 1'b0);
        chk("ng_winner", winner, 2'b00);

        // ---------------- simultaneous hits -> draw ----------------
        hit_op = 1'b1;
        hit_local = 1'b1;
        tick();
        tick();
        chk("draw_hp_1", hp, 2'd1);
        chk("draw_hp_op_1", hp_op, 2'd1);
        tick();
        chk("draw_hp_0", hp, 2'd0);
        chk("draw_hp_op_0", hp_op, 2'd0);
        hit_op = 1'b0;
        hit_local = 1'b0;
        tick();
        chk("draw_winner", winner, 2'b11);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;

        // ---------------- opponent channel ----------------
        shot_req_op = 1'b1;
        tick();
        chk("op_fire", fire_op, 1'b1);
        shot_req_op = 1'b0;
        busy_op = 1'b1;
        tick();
        chk("op_fire_one_cycle", fire_op, 1'b0);
        busy_op = 1'b0;
        tick();
        chk("op_reload", reloading_op, 1'b1);
        chk("local_independent", reloading, 1'b0);
        shot_req_op = 1'b1;
        tick();
        chk("op_req_in_reload_dropped", fire_op, 1'b0);
        shot_req_op = 1'b0;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        chk("ng_clears_op_reload", reloading_op, 1'b0);

        // ---------------- event queue ----------------
        tx_ready = 1'b0;
        tick();
        left_click = 1'b1;
        tick();
        chk("q_fire", fire, 1'b1);
        left_click = 1'b0;
        tick();
        chk("q_valid_1", tx_valid, 1'b1);
        chk("q_head_fired", tx_event, 2'b01);
        hit_local = 1'b1;
        tick();
        chk("q_head_stable", tx_event, 2'b01);
        tick();
        hit_local = 1'b0;
        chk("q_head_stable_full", tx_event, 2'b01);
        chk("q_hp_op_after_hits", hp_op, 2'd1);
        tx_ready = 1'b1;
        tick();
        chk("q_valid_after_pop1", tx_valid, 1'b1);
        chk("q_head_hit", tx_event, 2'b10);
        tick();
        chk("q_empty_after_pop2", tx_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shot_scheduler.md
Name: shot_scheduler

Overview:
- Sequences firing for both tanks: the local tank (mouse) and the opponent tank (link request).
- Turns fire requests into single-cycle fire pulses for each gun controller.
- Enforces in-flight exclusivity and a reload cooldown per tank.
- Tracks hit points from hit pulses, declares game over, and queues shot/hit events onto the shared serial-link TX port through a valid/ready handshake.

Parameters:
RELOAD_CYCLES, 195000000, cooldown length after a bullet ends, in clk cycles
HP_INIT, 3, starting hit points per tank (1..3)
START_TO, 8, cycles to wait for gun busy to rise after a fire pulse before giving up
CNT_W, 28, reload counter width (must hold RELOAD_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
new_game  in  1  pulse: restart match
left_click  in  1  raw mouse left button level
select  in  1  local tank selected
shot_req_op  in  1  pulse: opponent fire request decoded from link
busy  in  1  local gun controller not IDLE
busy_op  in  1  opponent gun controller not IDLE
hit_local  in  1  pulse: local bullet hit opponent (tank_central_hit)
hit_op  in  1  pulse: opponent bullet hit local tank
fire  out  1  pulse to local gun controller
fire_op  out  1  pulse to opponent gun controller
reloading  out  1  local channel in RELOAD
reloading_op  out  1  opponent channel in RELOAD
hp  out  2  local hit points
hp_op  out  2  opponent hit points
game_over  out  1  match ended
winner  out  2  00 none, 01 local, 10 opponent, 11 draw
tx_valid  out  1  event available on link
tx_event  out  2  01 local fired, 10 local hit confirmed
tx_ready  in  1  link accepts event

Behaviour:
- Reset (rst low, asynchronous) state:
  - Both channels in IDLE.
  - fire, fire_op, reloading, reloading_op, tx_valid, game_over all 0.
  - winner = 00, tx_event = 00, hp = hp_op = HP_INIT.
  - Click edge register = 0; event queue empty.
- Local request: rising edge of left_click (registered previous level) while select = 1. A held click fires once only.
- Opponent request: shot_req_op = 1.
- Per-channel FSM (local and opponent are identical and independent):
  - IDLE -> ARM on a request, if game_over = 0. The fire pulse is asserted for exactly the one cycle after the request cycle.
  - ARM -> FLIGHT when busy = 1 (or busy_op for the opponent channel).
  - ARM -> RELOAD after START_TO cycles with busy still low (lost shot).
  - FLIGHT -> RELOAD on the cycle busy = 0; the counter loads 0.
  - RELOAD -> IDLE when the counter reaches RELOAD_CYCLES-1. reloading = 1 throughout RELOAD.
  - Requests in ARM, FLIGHT or RELOAD are dropped, not queued.
- HP:
  - hit_local decrements hp_op; hit_op decrements hp. Both saturate at 0.
  - Hits are ignored when game_over = 1.
  - Simultaneous hit_local and hit_op apply both in the same cycle.
- Game over:
  - Registered 1 cycle after any hp reaches 0.
  - winner = 01 if only hp_op = 0; 10 if only hp = 0; 11 if both reach 0 in the same cycle.
  - While game_over = 1, new requests are blocked. Channels already in flight finish normally.
- new_game (synchronous, takes precedence over all other inputs in its cycle):
  - hp and hp_op reload to HP_INIT; game_over = 0; winner = 00.
  - Both FSMs return to IDLE; fire outputs are 0.
  - Event queue is flushed; tx_valid = 0.
- Event queue: 2-entry FIFO with fixed priority on simultaneous push.
  - Push "local fired" (01) in the cycle fire is asserted.
  - Push "local hit confirmed" (10) on hit_local when it is not ignored.
  - If both push in the same cycle, 01 enters first.
  - Pushes are dropped when the queue is full.
  - tx_valid = 1 whenever the queue is non-empty; tx_event shows the head entry.
  - Pop on tx_valid & tx_ready. Pop and push in the same cycle is allowed; occupancy stays the same.
  - tx_event must hold stable while tx_valid = 1 and tx_ready = 0.
- Width rules: counters must not wrap; the reload counter is CNT_W bits unsigned.

Test Plan:
- Reset, then set RELOAD_CYCLES = 20, select = 1. Pulse left_click for 1 cycle; busy rises 2 cycles later and falls 10 cycles later. Expect: fire high for exactly 1 cycle; reloading high for 20 cycles; a second click during reloading produces no fire; a click after reloading clears fires again.
- Hold left_click high for 50 cycles -> exactly one fire pulse.
- Fire with busy never rising, START_TO = 8 -> reloading asserts 8 cycles after the fire pulse and no hang occurs.
- Three hit_op pulses with HP_INIT = 3 -> hp goes 3,2,1,0; game_over = 1 and winner = 10 one cycle later; a further click gives fire = 0. Then pulse new_game -> hp = hp_op = 3 and game_over = 0.
- hit_local and hit_op asserted together with hp = hp_op = 1 -> both hp values become 0; winner = 11.
- Hold tx_ready = 0, fire once, then hit_local -> queue holds 01 then 10 and a third event is dropped. Raise tx_ready -> 01 is sent, then 10; tx_valid drops after 2 transfers.
